// File: rtl/any1_pkg.sv
// Shared types for the any1 branch resolve queue: queue entry payload and flush FSM states.
package any1_pkg;

  localparam int unsigned BRQ_AW    = 32;
  localparam int unsigned BRQ_DEPTH = 8;

  typedef struct packed {
    logic [BRQ_AW-1:0] ip;
    logic              pred_taken;
  } brq_entry_t;

  typedef enum logic {BRQ_RUN, BRQ_FLUSH} brq_state_t;

  localparam int unsigned BRQ_EW = $bits(brq_entry_t);

  // Restart address after a mispredicted branch.
  function automatic logic [BRQ_AW-1:0] brq_redirect(input logic              takb,
                                                     input logic [BRQ_AW-1:0] target,
                                                     input logic [BRQ_AW-1:0] fallthru);
    return takb ? target : fallthru;
  endfunction

endpackage

// File: rtl/any1_brq_fifo.sv
// Branch queue storage: circular buffer with wrap-bit pointers, full/empty/count and synchronous clear.
module any1_brq_fifo
  import any1_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned W     = BRQ_EW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Clear wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q[IW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[IW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/any1_branch_resolve_queue.sv
// Execute-side branch resolve queue: matches resolved branches against fetch predictions, updates the predictor.
// Optional build macro ANY1_BRQ_STATS_EN adds saturating branch/mispredict statistics counters.
module any1_branch_resolve_queue
  import any1_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned AW    = BRQ_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    fq_push,
  input  logic [AW-1:0]           fq_ip,
  input  logic                    fq_pred_taken,
  output logic                    fq_full,
  output logic [$clog2(DEPTH):0]  fq_count,
  input  logic                    ex_valid,
  input  logic [AW-1:0]           ex_ip,
  input  logic                    ex_takb,
  input  logic [AW-1:0]           ex_target,
  input  logic [AW-1:0]           ex_fallthru,
  output logic                    upd_valid,
  output logic [AW-1:0]           upd_ip,
  output logic                    upd_takb,
  output logic                    mispredict,
  output logic [AW-1:0]           redirect_ip,
`ifdef ANY1_BRQ_STATS_EN
  output logic [31:0]             stat_branches,
  output logic [31:0]             stat_mispred,
`endif
  output logic                    tag_err
);

  if (AW != BRQ_AW) begin : g_aw_chk
    $error("AW must equal the package entry address width");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of 2 and at least 2");
  end

  brq_state_t  state_q, state_d;
  brq_entry_t  head, wentry;
  logic        empty, full;
  logic        pop_c, hit_c, mis_c, push_c, clr_c;

  logic          upd_valid_q, upd_valid_d;
  logic [AW-1:0] upd_ip_q, upd_ip_d;
  logic          upd_takb_q, upd_takb_d;
  logic          mispredict_q, mispredict_d;
  logic [AW-1:0] redirect_ip_q, redirect_ip_d;
  logic          tag_err_q, tag_err_d;

  assign wentry = '{ip: fq_ip, pred_taken: fq_pred_taken};

  any1_brq_fifo #(
    .DEPTH (DEPTH),
    .W     (BRQ_EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fq_count)
  );

  // Next state, queue control and registered-output next values.
  always_comb begin
    state_d       = state_q;
    upd_valid_d   = 1'b0;
    upd_ip_d      = '0;
    upd_takb_d    = 1'b0;
    mispredict_d  = 1'b0;
    redirect_ip_d = '0;
    tag_err_d     = 1'b0;

    pop_c  = en && ex_valid && !empty;
    hit_c  = pop_c && (head.ip == ex_ip);
    mis_c  = hit_c && (head.pred_taken != ex_takb);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    push_c = en && fq_push && (state_q == BRQ_RUN) && !mis_c && (!full || pop_c);
    clr_c  = mis_c || (state_q == BRQ_FLUSH);

    if (en && ex_valid && (empty || !hit_c)) tag_err_d = 1'b1;
    if (hit_c) begin
      upd_valid_d = 1'b1;
      upd_ip_d    = ex_ip;
      upd_takb_d  = ex_takb;
    end
    if (mis_c) begin
      mispredict_d  = 1'b1;
      redirect_ip_d = brq_redirect(ex_takb, ex_target, ex_fallthru);
    end

    case (state_q)
      BRQ_RUN:   if (mis_c) state_d = BRQ_FLUSH;
      BRQ_FLUSH: if (en)    state_d = BRQ_RUN;
      default:              state_d = BRQ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BRQ_RUN;
      upd_valid_q   <= 1'b0;
      upd_ip_q      <= '0;
      upd_takb_q    <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_ip_q <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      upd_valid_q   <= upd_valid_d;
      upd_ip_q      <= upd_ip_d;
      upd_takb_q    <= upd_takb_d;
      mispredict_q  <= mispredict_d;
      redirect_ip_q <= redirect_ip_d;
      tag_err_q     <= tag_err_d;
    end
  end

  assign fq_full     = full;
  assign upd_valid   = upd_valid_q;
  assign upd_ip      = upd_ip_q;
  assign upd_takb    = upd_takb_q;
  assign mispredict  = mispredict_q;
  assign redirect_ip = redirect_ip_q;
  assign tag_err     = tag_err_q;

`ifdef ANY1_BRQ_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  // Saturating event counters.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (hit_c && stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
    if (mis_c && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_any1_branch_resolve_queue.sv
// Directed self-checking bench for any1_branch_resolve_queue (stats ports used when ANY1_BRQ_STATS_EN is defined).
module tb_any1_branch_resolve_queue;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fq_push;
  logic [AW-1:0] fq_ip;
  logic          fq_pred_taken;
  logic          fq_full;
  logic [CW-1:0] fq_count;
  logic          ex_valid;
  logic [AW-1:0] ex_ip;
  logic          ex_takb;
  logic [AW-1:0] ex_target;
  logic [AW-1:0] ex_fallthru;
  logic          upd_valid;
  logic [AW-1:0] upd_ip;
  logic          upd_takb;
  logic          mispredict;
  logic [AW-1:0] redirect_ip;
  logic          tag_err;
`ifdef ANY1_BRQ_STATS_EN
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  any1_branch_resolve_queue #(.DEPTH(8), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fq_push       (fq_push),
    .fq_ip         (fq_ip),
    .fq_pred_taken (fq_pred_taken),
    .fq_full       (fq_full),
    .fq_count      (fq_count),
    .ex_valid      (ex_valid),
    .ex_ip         (ex_ip),
    .ex_takb       (ex_takb),
    .ex_target     (ex_target),
    .ex_fallthru   (ex_fallthru),
    .upd_valid     (upd_valid),
    .upd_ip        (upd_ip),
    .upd_takb      (upd_takb),
    .mispredict    (mispredict),
    .redirect_ip   (redirect_ip),
`ifdef ANY1_BRQ_STATS_EN
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred),
`endif
    .tag_err       (tag_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fq_push = 1'b0; fq_ip = '0; fq_pred_taken = 1'b0;
    ex_valid = 1'b0; ex_ip = '0; ex_takb = 1'b0; ex_target = '0; ex_fallthru = '0;
  endtask

  task automatic push(input logic [AW-1:0] ip, input logic pred);
    fq_push = 1'b1; fq_ip = ip; fq_pred_taken = pred;
  endtask

  task automatic resolve(input logic [AW-1:0] ip, input logic takb,
                         input logic [AW-1:0] tgt, input logic [AW-1:0] ft);
    ex_valid = 1'b1; ex_ip = ip; ex_takb = takb; ex_target = tgt; ex_fallthru = ft;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; idle();
    #2;
    checks++;
    if ({upd_valid, upd_takb, mispredict, tag_err, fq_full} !== 5'b0 || fq_count !== 4'd0 ||
        upd_ip !== '0 || redirect_ip !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b count=%0d upd_ip=%h redir=%h, want all 0",
               {upd_valid, upd_takb, mispredict, tag_err, fq_full}, fq_count, upd_ip, redirect_ip);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_match();
    push(32'h100, 1'b1); tick(); idle();
    checks++;
    if (fq_count !== 4'd1) begin errors++; $display("FAIL match_count1: got %0d want 1", fq_count); end
    resolve(32'h100, 1'b1, 32'h180, 32'h104); tick(); idle();
    checks++;
    if (upd_valid !== 1'b1 || upd_ip !== 32'h100 || upd_takb !== 1'b1 || mispredict !== 1'b0 || tag_err !== 1'b0) begin
      errors++;
      $display("FAIL match_update: v=%b ip=%h takb=%b mp=%b te=%b want 1 100 1 0 0",
               upd_valid, upd_ip, upd_takb, mispredict, tag_err);
    end
    checks++;
    if (fq_count !== 4'd0) begin errors++; $display("FAIL match_count0: got %0d want 0", fq_count); end
    tick();
    checks++;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL match_pulse: upd_valid=%b want 0", upd_valid); end
  endtask

  task automatic test_mispredict_taken();
    push(32'h200, 1'b0); tick(); idle();
    resolve(32'h200, 1'b1, 32'h400, 32'h204); tick(); idle();
    checks++;
    if (mispredict !== 1'b1 || redirect_ip !== 32'h400 || upd_valid !== 1'b1 || upd_takb !== 1'b1) begin
      errors++;
      $display("FAIL mp_taken: mp=%b redir=%h v=%b takb=%b want 1 400 1 1",
               mispredict, redirect_ip, upd_valid, upd_takb);
    end
    checks++;
    if (fq_count !== 4'd0) begin errors++; $display("FAIL mp_taken_count: got %0d want 0", fq_count); end
    tick();
    checks++;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL mp_pulse: mispredict=%b want 0", mispredict); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + 32'(4 * i), 1'(i % 2)); tick();
    end
    idle();
    checks++;
    if (fq_full !== 1'b1 || fq_count !== 4'd8) begin
      errors++; $display("FAIL full_flag: full=%b count=%0d want 1 8", fq_full, fq_count);
    end
    push(32'h2000, 1'b1); tick(); idle();
    checks++;
    if (fq_count !== 4'd8) begin errors++; $display("FAIL full_drop: count=%0d want 8", fq_count); end
    push(32'h3000, 1'b0); resolve(32'h1000, 1'b0, '0, '0); tick(); idle();
    checks++;
    if (fq_count !== 4'd8 || upd_valid !== 1'b1 || upd_ip !== 32'h1000 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d v=%b ip=%h mp=%b want 8 1 1000 0",
               fq_count, upd_valid, upd_ip, mispredict);
    end
    for (int i = 1; i < 9; i++) begin
      logic [AW-1:0] eip;
      logic          ep;
      eip = (i < 8) ? 32'h1000 + 32'(4 * i) : 32'h3000;
      ep  = (i < 8) ? 1'(i % 2) : 1'b0;
      resolve(eip, ep, '0, '0); tick(); idle();
      checks++;
      if (upd_valid !== 1'b1 || upd_ip !== eip || upd_takb !== ep || tag_err !== 1'b0 || mispredict !== 1'b0) begin
        errors++;
        $display("FAIL fifo_order[%0d]: v=%b ip=%h takb=%b te=%b mp=%b want 1 %h %b 0 0",
                 i, upd_valid, upd_ip, upd_takb, tag_err, mispredict, eip, ep);
      end
    end
    checks++;
    if (fq_count !== 4'd0 || fq_full !== 1'b0) begin
      errors++; $display("FAIL full_drain: count=%0d full=%b want 0 0", fq_count, fq_full);
    end
  endtask

  task automatic test_flush();
    push(32'h300, 1'b1); tick();
    push(32'h308, 1'b1); tick(); idle();
    push(32'h310, 1'b1); resolve(32'h300, 1'b0, 32'h900, 32'h304); tick(); idle();
    checks++;
    if (mispredict !== 1'b1 || redirect_ip !== 32'h304 || upd_takb !== 1'b0 || fq_count !== 4'd0) begin
      errors++;
      $display("FAIL flush_redirect: mp=%b redir=%h takb=%b count=%0d want 1 304 0 0",
               mispredict, redirect_ip, upd_takb, fq_count);
    end
    push(32'h318, 1'b1); tick(); idle();
    checks++;
    if (fq_count !== 4'd0) begin errors++; $display("FAIL flush_push_ignored: count=%0d want 0", fq_count); end
  endtask

  task automatic test_tag_err();
    resolve(32'h500, 1'b1, '0, '0); tick(); idle();
    checks++;
    if (tag_err !== 1'b1 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL tag_empty: te=%b v=%b want 1 0", tag_err, upd_valid);
    end
    push(32'h500, 1'b1); tick(); idle();
    resolve(32'h504, 1'b1, '0, '0); tick(); idle();
    checks++;
    if (tag_err !== 1'b1 || upd_valid !== 1'b0 || mispredict !== 1'b0 || fq_count !== 4'd0) begin
      errors++;
      $display("FAIL tag_mismatch: te=%b v=%b mp=%b count=%0d want 1 0 0 0",
               tag_err, upd_valid, mispredict, fq_count);
    end
    tick();
    checks++;
    if (tag_err !== 1'b0) begin errors++; $display("FAIL tag_pulse: te=%b want 0", tag_err); end
  endtask

  task automatic test_enable();
    en = 1'b0;
    push(32'h700, 1'b1); tick(); idle();
    checks++;
    if (fq_count !== 4'd0) begin errors++; $display("FAIL en_push: count=%0d want 0", fq_count); end
    en = 1'b1;
    push(32'h700, 1'b1); tick(); idle();
    en = 1'b0;
    resolve(32'h700, 1'b1, '0, '0); tick(); idle();
    checks++;
    if (fq_count !== 4'd1 || upd_valid !== 1'b0 || tag_err !== 1'b0) begin
      errors++; $display("FAIL en_pop: count=%0d v=%b te=%b want 1 0 0", fq_count, upd_valid, tag_err);
    end
    en = 1'b1;
    resolve(32'h700, 1'b1, '0, '0); tick(); idle();
    checks++;
    if (upd_valid !== 1'b1 || upd_ip !== 32'h700 || fq_count !== 4'd0) begin
      errors++; $display("FAIL en_resume: v=%b ip=%h count=%0d want 1 700 0", upd_valid, upd_ip, fq_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      push(32'h600 + 32'(4 * i), 1'b0); tick();
    end
    idle();
    resolve(32'h600, 1'b0, '0, '0); tick(); idle();
    checks++;
    if (fq_count !== 4'd5 || upd_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset: count=%0d v=%b want 5 1", fq_count, upd_valid);
    end
`ifdef ANY1_BRQ_STATS_EN
    checks++;
    if (stat_branches !== 32'd14 || stat_mispred !== 32'd2) begin
      errors++; $display("FAIL stats_pre: br=%0d mp=%0d want 14 2", stat_branches, stat_mispred);
    end
`endif
    #2 rst = 1'b0;
    #1;
    checks++;
    if (fq_count !== 4'd0 || upd_valid !== 1'b0 || upd_ip !== '0 || fq_full !== 1'b0) begin
      errors++; $display("FAIL async_reset: count=%0d v=%b ip=%h full=%b want 0 0 0 0",
                         fq_count, upd_valid, upd_ip, fq_full);
    end
`ifdef ANY1_BRQ_STATS_EN
    checks++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL stats_reset: br=%0d mp=%0d want 0 0", stat_branches, stat_mispred);
    end
`endif
    tick();
    rst = 1'b1;
    tick();
    push(32'h800, 1'b1); tick(); idle();
    checks++;
    if (fq_count !== 4'd1) begin errors++; $display("FAIL post_reset_push: count=%0d want 1", fq_count); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mispredict_taken();
    test_full();
    test_flush();
    test_tag_err();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
